// File: rtl/alu_rs_pkg.sv
// Shared defines for the ALU reservation station:
// ROB tag width, ALU op encodings, entry layout.
package alu_rs_pkg;

  localparam int ROB_WIDTH = 4;

  typedef logic [ROB_WIDTH-1:0] rob_tag_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_SLT  = 5'd3,
    OP_SLTU = 5'd4,
    OP_XOR  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_OR   = 5'd8,
    OP_AND  = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_BLTU = 5'd14,
    OP_BGEU = 5'd15,
    OP_NOP  = 5'd16
  } alu_op_e;

  typedef struct packed {
    logic        busy;
    logic [4:0]  op;
    logic [31:0] vj;
    logic        qj_valid;
    rob_tag_t    qj;
    logic [31:0] vk;
    logic        qk_valid;
    rob_tag_t    qk;
    rob_tag_t    rob_id;
    logic [31:0] true_jaddr;
    logic [31:0] false_jaddr;
  } rs_entry_t;

  // {hit, value}; ALU bus wins so an X on the LSB side never leaks in
  function automatic logic [32:0] bus_hit(
    input logic        a_rdy,
    input rob_tag_t    a_id,
    input logic [31:0] a_val,
    input logic        l_rdy,
    input rob_tag_t    l_id,
    input logic [31:0] l_val,
    input rob_tag_t    tag
  );
    if (a_rdy && a_id == tag) return {1'b1, a_val};
    if (l_rdy && l_id == tag) return {1'b1, l_val};
    return '0;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Decoder-to-station dispatch bundle with
// back-pressure (full).
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  rob_tag_t    dispatch_rob_id;
  logic [31:0] dispatch_true_jaddr;
  logic [31:0] dispatch_false_jaddr;
  logic [31:0] dispatch_vj;
  logic        dispatch_qj_valid;
  rob_tag_t    dispatch_qj;
  logic [31:0] dispatch_vk;
  logic        dispatch_qk_valid;
  rob_tag_t    dispatch_qk;
  logic        full;

  modport master (
    output dispatch_valid, dispatch_op,
    output dispatch_rob_id,
    output dispatch_true_jaddr,
    output dispatch_false_jaddr,
    output dispatch_vj, dispatch_qj_valid,
    output dispatch_qj,
    output dispatch_vk, dispatch_qk_valid,
    output dispatch_qk,
    input  full
  );

  modport slave (
    input  dispatch_valid, dispatch_op,
    input  dispatch_rob_id,
    input  dispatch_true_jaddr,
    input  dispatch_false_jaddr,
    input  dispatch_vj, dispatch_qj_valid,
    input  dispatch_qj,
    input  dispatch_vk, dispatch_qk_valid,
    input  dispatch_qk,
    output full
  );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit encoder with a valid flag,
// used for free-slot and issue selection.
module rs_prio_enc #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops
// until operands arrive, issues one per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear,
  alu_rs_if.slave        disp,
  input  logic           alu_ready,
  input  rob_tag_t       alu_rob_id,
  input  logic [31:0]    alu_value,
  input  logic           lsb_ready,
  input  rob_tag_t       lsb_rob_id,
  input  logic [31:0]    lsb_value,
  output logic           calc_enable,
  output logic [31:0]    lhs,
  output logic [31:0]    rhs,
  output logic [4:0]     op,
  output rob_tag_t       rob_dep,
  output logic [31:0]    true_jaddr,
  output logic [31:0]    false_jaddr
);

  localparam int IW = $clog2(RS_SIZE);

  rs_entry_t          rs [RS_SIZE];
  logic [RS_SIZE-1:0] busy_v;
  logic [RS_SIZE-1:0] ready_v;
  logic [32:0]        wj [RS_SIZE];
  logic [32:0]        wk [RS_SIZE];
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      iss_idx;
  logic               free_ok;
  logic               iss_ok;
  logic               do_disp;
  logic [32:0]        fj;
  logic [32:0]        fk;
  rs_entry_t          new_e;

  always_comb begin
    busy_v  = '0;
    ready_v = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_v[i]  = rs[i].busy;
      ready_v[i] = rs[i].busy
                 & ~rs[i].qj_valid
                 & ~rs[i].qk_valid;
      wj[i] = bus_hit(alu_ready, alu_rob_id,
                      alu_value, lsb_ready,
                      lsb_rob_id, lsb_value,
                      rs[i].qj);
      wk[i] = bus_hit(alu_ready, alu_rob_id,
                      alu_value, lsb_ready,
                      lsb_rob_id, lsb_value,
                      rs[i].qk);
    end
  end

  assign disp.full = &busy_v;

  rs_prio_enc #(.N(RS_SIZE)) u_free (
    .req   (~busy_v),
    .idx   (free_idx),
    .valid (free_ok)
  );

  rs_prio_enc #(.N(RS_SIZE)) u_issue (
    .req   (ready_v),
    .idx   (iss_idx),
    .valid (iss_ok)
  );

  assign do_disp = rdy_in & disp.dispatch_valid
                 & free_ok & ~clear;

  always_comb begin
    fj = bus_hit(alu_ready, alu_rob_id, alu_value,
                 lsb_ready, lsb_rob_id, lsb_value,
                 disp.dispatch_qj);
    fk = bus_hit(alu_ready, alu_rob_id, alu_value,
                 lsb_ready, lsb_rob_id, lsb_value,
                 disp.dispatch_qk);
    new_e             = '0;
    new_e.busy        = 1'b1;
    new_e.op          = disp.dispatch_op;
    new_e.rob_id      = disp.dispatch_rob_id;
    new_e.true_jaddr  = disp.dispatch_true_jaddr;
    new_e.false_jaddr = disp.dispatch_false_jaddr;
    new_e.qj          = disp.dispatch_qj;
    new_e.qk          = disp.dispatch_qk;
    new_e.vj          = disp.dispatch_vj;
    new_e.vk          = disp.dispatch_vk;
    new_e.qj_valid    = disp.dispatch_qj_valid;
    new_e.qk_valid    = disp.dispatch_qk_valid;
    if (disp.dispatch_qj_valid && fj[32]) begin
      new_e.vj       = fj[31:0];
      new_e.qj_valid = 1'b0;
    end
    if (disp.dispatch_qk_valid && fk[32]) begin
      new_e.vk       = fk[31:0];
      new_e.qk_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++)
        rs[i] <= '0;
      calc_enable <= 1'b0;
      lhs         <= '0;
      rhs         <= '0;
      op          <= '0;
      rob_dep     <= '0;
      true_jaddr  <= '0;
      false_jaddr <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++)
          rs[i].busy <= 1'b0;
        calc_enable <= 1'b0;
        lhs         <= '0;
        rhs         <= '0;
        op          <= '0;
        rob_dep     <= '0;
        true_jaddr  <= '0;
        false_jaddr <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (rs[i].busy && rs[i].qj_valid
              && wj[i][32]) begin
            rs[i].vj       <= wj[i][31:0];
            rs[i].qj_valid <= 1'b0;
          end
          if (rs[i].busy && rs[i].qk_valid
              && wk[i][32]) begin
            rs[i].vk       <= wk[i][31:0];
            rs[i].qk_valid <= 1'b0;
          end
        end
        calc_enable <= iss_ok;
        if (iss_ok) begin
          lhs         <= rs[iss_idx].vj;
          rhs         <= rs[iss_idx].vk;
          op          <= rs[iss_idx].op;
          rob_dep     <= rs[iss_idx].rob_id;
          true_jaddr  <= rs[iss_idx].true_jaddr;
          false_jaddr <= rs[iss_idx].false_jaddr;
          rs[iss_idx].busy <= 1'b0;
        end else begin
          lhs         <= '0;
          rhs         <= '0;
          op          <= '0;
          rob_dep     <= '0;
          true_jaddr  <= '0;
          false_jaddr <= '0;
        end
        // the free slot is never the issuing one
        if (do_disp) rs[free_idx] <= new_e;
      end
    end
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of station entries (power of two, 2..16).
REQ-002 SHALL use ROB_WIDTH from the shared defines, default 4, ROB tag width.
REQ-003 SHALL have port clk_in  input  1  system clock; one clock domain.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-006 SHALL have port clear  input  1  misprediction flush.
REQ-007 SHALL have ports dispatch_valid 1, dispatch_op 5, dispatch_rob_id ROB_WIDTH, dispatch_true_jaddr 32, dispatch_false_jaddr 32  inputs  new instruction from decoder.
REQ-008 SHALL have ports dispatch_vj 32, dispatch_qj_valid 1, dispatch_qj ROB_WIDTH, and the same three for k  inputs  operand value or pending ROB tag.
REQ-009 SHALL have ports alu_ready 1, alu_rob_id ROB_WIDTH, alu_value 32  inputs  ALU result broadcast (fed back from ALU outputs).
REQ-010 SHALL have ports lsb_ready 1, lsb_rob_id ROB_WIDTH, lsb_value 32  inputs  load/store result broadcast.
REQ-011 SHALL have port full  output  1  no free entry; decoder must not dispatch.
REQ-012 SHALL have ports calc_enable 1, lhs 32, rhs 32, op 5, rob_dep ROB_WIDTH, true_jaddr 32, false_jaddr 32  outputs  registered issue to ALU.

Function
REQ-013 Entry fields: busy, op, vj, qj_valid, qj, vk, qk_valid, qk, rob_id, true_jaddr, false_jaddr.
REQ-014 full SHALL be combinational from registered busy bits: high iff all RS_SIZE entries busy.
REQ-015 Dispatch (rdy_in & dispatch_valid & !full & !clear) SHALL write the lowest-index free entry at the clock edge.
REQ-016 Dispatch with full high SHALL be ignored; no entry changes.
REQ-017 Dispatch forwarding: if qj_valid and a broadcast with matching tag is valid that cycle, entry SHALL store the broadcast value with qj_valid=0; same for k; ALU bus checked before LSB (tags are unique, order only matters for X-safety).
REQ-018 Wakeup: each busy entry with qj_valid and qj matching a valid broadcast SHALL capture value, clear qj_valid at the edge; same for k; both operands may wake in one cycle.
REQ-019 Eligibility: busy & !qj_valid & !qk_valid, from registered state only; entry woken or dispatched at edge N is first eligible in cycle N+1.
REQ-020 Issue: at most one per cycle, lowest-index eligible entry; at the edge SHALL register calc_enable=1, lhs=vj, rhs=vk, op, rob_dep=rob_id, true_jaddr, false_jaddr, and clear busy.
REQ-021 With no eligible entry, calc_enable SHALL register 0 and data outputs 0.
REQ-022 Minimum latency: dispatch with both operands ready at edge N -> calc_enable high after edge N+1.
REQ-023 Simultaneous dispatch and issue SHALL both occur; freed slot is allocatable from the next cycle only.
REQ-024 clear with rdy_in high SHALL clear all busy bits and register calc_enable=0, data 0; dispatch and wakeup that cycle ignored.
REQ-025 rdy_in low SHALL hold all entries and all outputs unchanged; broadcasts that cycle are ignored.
REQ-026 Immediate forms: decoder supplies immediate in vk with qk_valid=0; station treats it as ordinary operand (rhs[10] carries shift-arith select).

Reset
REQ-027 rst_in low SHALL immediately clear all busy bits, calc_enable=0, lhs, rhs, true_jaddr, false_jaddr=0, op=0, rob_dep=0; full therefore 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; no issue occurs on the first edge after release unless dispatched earlier after release.

Structure
REQ-029 ROB_WIDTH and ALU op encodings (ADD..AND, BEQ..BGEU, NOP) SHALL live in the shared defines header, not in this module.
REQ-030 A sub-module rs_prio_enc (RS_SIZE-bit lowest-set-bit encoder with valid flag) SHALL be instantiated twice: free-slot select and issue select.

Verification
REQ-031 Dispatch ADD vj=5, vk=7 both ready at edge 0 -> calc_enable=1, lhs=5, rhs=7, op=ADD after edge 1, then 0.
REQ-032 Dispatch SUB with qj=3 pending; alu_ready, alu_rob_id=3, alu_value=0x10 two cycles later -> issue lhs=0x10 one edge after the broadcast edge.
REQ-033 Fill 8 entries all pending -> full=1; 9th dispatch ignored; one wakeup and issue -> full=0 the cycle after issue.
REQ-034 Entries 2 and 5 become eligible same edge -> entry 2 issues first, entry 5 next cycle.
REQ-035 Dispatch with qk=6 while lsb_ready, lsb_rob_id=6, lsb_value=0xAB same cycle -> entry stores 0xAB, issues with rhs=0xAB.
REQ-036 Three busy entries, clear pulse -> full=0, calc_enable=0 next cycle, no later issue; rst_in low mid-run -> outputs 0 immediately.
